// File: rtl/dogx_alpha_range_ctrl_if.sv
// Sample/threshold bus between the DOGX front end and the alpha range controller,
// with the controller's registered decision and status outputs.
interface dogx_alpha_range_ctrl_if #(
  parameter int DATA_W = 10,
  parameter int TH_W   = 9,
  parameter int TMO_W  = 5,
  parameter int CNT_W  = 16
);
  logic                     enable;
  logic                     sample_valid;
  logic signed [DATA_W-1:0] sample_hsnr;
  logic        [TH_W-1:0]   th_high;
  logic        [TH_W-1:0]   th_low;
  logic        [TMO_W-1:0]  timeout_mask;
  logic                     alpha;
  logic                     data_hold;
  logic                     switch_pulse;
  logic        [2:0]        state;
  logic                     cfg_err;
  logic        [CNT_W-1:0]  up_switches;

  modport master (
    output enable, sample_valid, sample_hsnr, th_high, th_low, timeout_mask,
    input  alpha, data_hold, switch_pulse, state, cfg_err, up_switches
  );

  modport slave (
    input  enable, sample_valid, sample_hsnr, th_high, th_low, timeout_mask,
    output alpha, data_hold, switch_pulse, state, cfg_err, up_switches
  );
endinterface

// File: rtl/dogx_alpha_range_ctrl.sv
// Alpha (range) controller: switches the converter between HSNR and HDR paths with
// threshold hysteresis, a quiet-sample timeout and a settle window that blanks the output.
module dogx_alpha_range_ctrl #(
  parameter int DATA_W     = 10,
  parameter int TH_W       = 9,
  parameter int TMO_W      = 5,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic                     CLK_3M,
  input  logic                     reset,
  dogx_alpha_range_ctrl_if.slave   bus
);

  localparam logic [2:0] S_HSNR   = 3'd0;
  localparam logic [2:0] S_SET_UP = 3'd1;
  localparam logic [2:0] S_HDR    = 3'd2;
  localparam logic [2:0] S_SET_DN = 3'd3;

  localparam int MAG_W  = DATA_W + 1;
  localparam int SCNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [SCNT_W-1:0] SETTLE_LOAD = SCNT_W'(SETTLE_CYC);

  logic [2:0]        state_q, state_d;
  logic [TMO_W-1:0]  tcnt_q, tcnt_d, tcnt_next;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0]  up_q;
  logic              alpha_q, hold_q, pulse_q, cfg_err_q;
  logic              alpha_d, hold_d, up_event;
  logic              quiet, loud;

  logic [MAG_W-1:0]  sample_ext, mag_full;
  logic [TH_W-1:0]   mag;

  // One extra bit so the most negative sample negates without overflow.
  assign sample_ext = {bus.sample_hsnr[DATA_W-1], bus.sample_hsnr};
  assign mag_full   = sample_ext[MAG_W-1] ? (~sample_ext) + MAG_W'(1) : sample_ext;

  if (MAG_W > TH_W) begin : g_sat
    assign mag = (|mag_full[MAG_W-1:TH_W]) ? '1 : mag_full[TH_W-1:0];
  end else begin : g_nosat
    assign mag = TH_W'(mag_full);
  end

  assign quiet = (mag <  bus.th_low);
  assign loud  = (mag >= bus.th_high);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    scnt_d    = scnt_q;
    tcnt_next = tcnt_q + TMO_W'(1);
    up_event  = 1'b0;

    if (!bus.enable) begin
      state_d = S_HSNR;
      tcnt_d  = '0;
      scnt_d  = '0;
    end else begin
      case (state_q)
        S_HSNR: begin
          if (bus.sample_valid && loud) begin
            state_d  = S_SET_UP;
            scnt_d   = SETTLE_LOAD;
            up_event = 1'b1;
          end
        end
        S_SET_UP: begin
          if (bus.sample_valid) begin
            scnt_d = scnt_q - SCNT_W'(1);
            if (scnt_q <= SCNT_W'(1)) begin
              state_d = S_HDR;
              scnt_d  = '0;
              tcnt_d  = '0;
            end
          end
        end
        S_HDR: begin
          if (bus.sample_valid) begin
            if (quiet) begin
              tcnt_d = tcnt_next;
              if ((tcnt_next & bus.timeout_mask) == bus.timeout_mask) begin
                state_d = S_SET_DN;
                scnt_d  = SETTLE_LOAD;
              end
            end else begin
              tcnt_d = '0;
            end
          end
        end
        S_SET_DN: begin
          if (bus.sample_valid) begin
            if (loud) begin
              state_d  = S_SET_UP;
              scnt_d   = SETTLE_LOAD;
              up_event = 1'b1;
            end else begin
              scnt_d = scnt_q - SCNT_W'(1);
              if (scnt_q <= SCNT_W'(1)) begin
                state_d = S_HSNR;
                scnt_d  = '0;
              end
            end
          end
        end
        default: state_d = S_HSNR;
      endcase
    end
  end

  // Path and blanking follow directly from the state being entered.
  assign alpha_d = (state_d == S_SET_UP) || (state_d == S_HDR);
  assign hold_d  = (state_d == S_SET_UP) || (state_d == S_SET_DN);

  always_ff @(posedge CLK_3M) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset) begin
      state_q   <= S_HSNR;
      tcnt_q    <= '0;
      scnt_q    <= '0;
      up_q      <= '0;
      alpha_q   <= 1'b0;
      hold_q    <= 1'b0;
      pulse_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      scnt_q    <= scnt_d;
      alpha_q   <= alpha_d;
      hold_q    <= hold_d;
      pulse_q   <= (alpha_d != alpha_q);
      cfg_err_q <= (bus.th_low > bus.th_high);
      if (up_event && !(&up_q)) up_q <= up_q + CNT_W'(1);
    end
  end

  assign bus.state        = state_q;
  assign bus.alpha        = alpha_q;
  assign bus.data_hold    = hold_q;
  assign bus.switch_pulse = pulse_q;
  assign bus.cfg_err      = cfg_err_q;
  assign bus.up_switches  = up_q;

endmodule
